// File: rtl/div_seq_ctrl.sv
// Multi-cycle restoring divider for the MIPS EX stage: one quotient bit per CALC cycle,
// stalls the front end while busy. Define DIV_SIGNED_EN for signed (div) semantics.
module div_seq_ctrl #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             stall_o,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_by_zero_o
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] rem_acc_q, q_sh_q, div_q;
   logic [WIDTH-1:0] quot_q, rem_q;
   logic             done_q, busy_q, dbz_q;

   // One restoring step; the extra bit keeps the shifted-out MSB of rem_acc.
   logic [WIDTH:0]   rem_shift, rem_diff;
   logic             rem_ge;
   logic [WIDTH-1:0] rem_nxt, q_nxt;

   always_comb begin
      rem_shift = {rem_acc_q, q_sh_q[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, div_q};
      rem_ge    = (rem_shift >= {1'b0, div_q});
      rem_nxt   = rem_ge ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      q_nxt     = {q_sh_q[WIDTH-2:0], rem_ge};
   end

   logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

`ifdef DIV_SIGNED_EN
   logic q_neg_q, r_neg_q;

   always_comb begin
      a_mag = dividend_i[WIDTH-1] ? (~dividend_i + 1'b1) : dividend_i;
      b_mag = divisor_i[WIDTH-1]  ? (~divisor_i + 1'b1)  : divisor_i;
      q_fix = q_neg_q ? (~q_nxt + 1'b1) : q_nxt;
      r_fix = r_neg_q ? (~rem_nxt + 1'b1) : rem_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_neg_q <= 1'b0;
         r_neg_q <= 1'b0;
      end else if (state_q == S_IDLE && start_i && !flush_i) begin
         q_neg_q <= dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
         r_neg_q <= dividend_i[WIDTH-1];
      end
   end
`else
   always_comb begin
      a_mag = dividend_i;
      b_mag = divisor_i;
      q_fix = q_nxt;
      r_fix = rem_nxt;
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_acc_q <= '0;
         q_sh_q    <= '0;
         div_q     <= '0;
         quot_q    <= '0;
         rem_q     <= '0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start_i && !flush_i) begin
                  div_q     <= b_mag;
                  q_sh_q    <= a_mag;
                  rem_acc_q <= '0;
                  cnt_q     <= '0;
                  if (divisor_i == '0) begin
                     // Skip iteration entirely; result is architecturally fixed.
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                     dbz_q   <= 1'b1;
                     quot_q  <= '1;
                     rem_q   <= dividend_i;
                  end else begin
                     state_q <= S_CALC;
                     busy_q  <= 1'b1;
                  end
               end
            end
            S_CALC: begin
               if (flush_i) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  rem_acc_q <= rem_nxt;
                  q_sh_q    <= q_nxt;
                  cnt_q     <= cnt_q + 1'b1;
                  if (cnt_q == CNT_W'(WIDTH-1)) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     dbz_q   <= 1'b0;
                     quot_q  <= q_fix;
                     rem_q   <= r_fix;
                  end
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Combinational on the IDLE leg so the div holds in EX from its first cycle.
   assign stall_o       = (state_q == S_IDLE && start_i && !flush_i) || (state_q == S_CALC);
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign quotient_o    = quot_q;
   assign remainder_o   = rem_q;
   assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed bench for div_seq_ctrl: latency, results, divide-by-zero, flush, reset, start hold.
module tb_div_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n, start, flush;
   logic [31:0] dividend, divisor;
   logic        stall, busy, done, dbz;
   logic [31:0] quotient, remainder;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   div_seq_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start), .flush_i(flush),
      .dividend_i(dividend), .divisor_i(divisor),
      .stall_o(stall), .busy_o(busy), .done_o(done),
      .quotient_o(quotient), .remainder_o(remainder), .div_by_zero_o(dbz)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issues one divide from IDLE and checks stall/busy/done every cycle until the done pulse.
   task automatic do_div(input string nm, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                         input bit hold);
      int lat;
      lat      = (b == 32'd0) ? 1 : 33;
      dividend = a;
      divisor  = b;
      start    = 1'b1;
      #1;
      checks++;
      if ({stall, done, busy} !== 3'b100) begin
         errors++;
         $display("FAIL %s issue: stall/done/busy=%b expected 100", nm, {stall, done, busy});
      end
      for (int k = 1; k <= lat; k++) begin
         step();
         if (k == 1) begin
            if (hold) begin
               dividend = a ^ 32'h0000_FFFF;
               divisor  = b + 32'd1;
            end else start = 1'b0;
         end
         #1;
         checks++;
         if (k < lat) begin
            if ({stall, done, busy} !== 3'b101) begin
               errors++;
               $display("FAIL %s calc cyc %0d: stall/done/busy=%b expected 101", nm, k,
                        {stall, done, busy});
            end
         end else begin
            if ({stall, done, busy, dbz, quotient, remainder} !== {3'b010, edbz, eq, er}) begin
               errors++;
               $display("FAIL %s done cyc %0d: s/d/b/z=%b q=%h r=%h expected s/d/b/z=010%b q=%h r=%h",
                        nm, k, {stall, done, busy, dbz}, quotient, remainder, edbz, eq, er);
            end
         end
      end
      start = 1'b0;
      step();
      checks++;
      if ({stall, done, busy} !== 3'b000) begin
         errors++;
         $display("FAIL %s post: stall/done/busy=%b expected 000", nm, {stall, done, busy});
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; flush = 1'b0; dividend = '0; divisor = '0;
      step();
      step();
      checks++;
      if ({stall, done, busy, dbz, quotient, remainder} !== 68'd0) begin
         errors++;
         $display("FAIL reset: s/d/b/z=%b q=%h r=%h expected all 0",
                  {stall, done, busy, dbz}, quotient, remainder);
      end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_unsigned();
      do_div("u100_7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
      do_div("u5_9", 32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b0);
      do_div("max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0);
      do_div("big_by_1", 32'hDEAD_BEEF, 32'd1, 32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
   endtask

   task automatic test_sign();
`ifdef DIV_SIGNED_EN
      do_div("s-7_2", 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0);
      do_div("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
`else
      do_div("u_fff9_2", 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 32'd1, 1'b0, 1'b0);
      do_div("u_min_max", 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0);
`endif
   endtask

   task automatic test_div_by_zero();
      do_div("dbz", 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1, 1'b0);
   endtask

   task automatic test_start_held();
      do_div("held", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
   endtask

   task automatic test_flush();
      dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         step();
         start = 1'b0;
      end
      flush = 1'b1;
      step();
      flush = 1'b0;
      for (int k = 0; k < 40; k++) begin
         checks++;
         if ({stall, done, busy, quotient, remainder} !== {3'b000, 32'd14, 32'd2}) begin
            errors++;
            $display("FAIL flush cyc %0d: s/d/b=%b q=%h r=%h expected 000 q=0000000e r=00000002",
                     k, {stall, done, busy}, quotient, remainder);
         end
         step();
      end
      // flush and start together in IDLE: no acceptance
      start = 1'b1; flush = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_start stall: got %b expected 0", stall);
      end
      step();
      start = 1'b0; flush = 1'b0;
      #1;
      checks++;
      if ({stall, done, busy} !== 3'b000) begin
         errors++;
         $display("FAIL flush_start idle: s/d/b=%b expected 000", {stall, done, busy});
      end
   endtask

   task automatic test_reset_mid();
      dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         start = 1'b0;
      end
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      checks++;
      if ({stall, done, busy, dbz, quotient, remainder} !== 68'd0) begin
         errors++;
         $display("FAIL reset_mid: s/d/b/z=%b q=%h r=%h expected all 0",
                  {stall, done, busy, dbz}, quotient, remainder);
      end
      step();
      do_div("after_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_div("b2b_a", 32'd200, 32'd7, 32'd28, 32'd4, 1'b0, 1'b0);
      do_div("b2b_b", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0);
      do_div("b2b_dbz", 32'd77, 32'd0, 32'hFFFF_FFFF, 32'd77, 1'b1, 1'b0);
      do_div("b2b_c", 32'd77, 32'd10, 32'd7, 32'd7, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_unsigned();
      test_sign();
      test_div_by_zero();
      test_start_held();
      test_flush();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
